// File: rtl/wr_phy_rst_pkg.sv
// Shared types and helpers for the WR transceiver reset/lock sequencer.
// Contents:
//   t_tx_state / t_rx_state  FSM state encodings
//   c_min_*                  smallest legal cycle counts; larger parameters are clamped up to these
//   f_log2_size              timer width able to hold (value-1) down to zero, at least 1 bit
//   f_max                    integer maximum for parameter arithmetic
package wr_phy_rst_pkg;

   typedef enum logic [1:0] {
      TX_ARST,
      TX_WAIT,
      TX_DRST,
      TX_READY
   } t_tx_state;

   typedef enum logic [2:0] {
      RX_ARST,
      RX_WAIT,
      RX_LTR,
      RX_LTD,
      RX_DRST,
      RX_READY
   } t_rx_state;

   localparam int c_min_analog_rst_cycles  = 1;
   localparam int c_min_digital_rst_cycles = 1;
   localparam int c_min_ltr_settle_cycles  = 1;
   localparam int c_min_ltd_timeout_cycles = 1;

   // Smallest n >= 1 with 2**n >= value. Timers load (count-1) and stop at zero,
   // so this is enough bits for any count up to 'value'.
   function automatic int f_log2_size(input int value);
      int n;
      n = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) n = i + 1;
      end
      return n;
   endfunction

   function automatic int f_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/wr_phy_rx_rst_chan.sv
// One RX reset/lock FSM plus its saturating relock counter.
// All lock/cal inputs arrive already synchronised to clk_sys_i.
// Ports:
//   clk_sys_i, rst_i            clock, synchronous active-high reset
//   rx_enable_i                 low holds the channel in analog reset
//   rx_cal_busy_i               synced rx_cal_busy
//   rx_is_lockedtoref_i         synced CDR lock-to-reference status
//   rx_is_lockedtodata_i        synced CDR lock-to-data status
//   tx_ready_i                  registered TX ready from the shared TX FSM
//   tx_drop_i                   TX ready will fall on this edge; forces RX_ARST
//   relock_clr_i                clears the relock counter (wins over increment)
//   rx_*reset_o, rx_set_*_o     registered PHY controls
//   rx_ready_o                  channel ready
//   relock_cnt_o                saturating count of lock losses / timeouts
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RX_ARST  | analog+digital reset held; also parked here while disabled
// RX_WAIT  | analog released, waiting for rx_cal_busy low and tx_ready
// RX_LTR   | CDR lock-to-ref, waiting for a continuous settle window
// RX_LTD   | CDR lock-to-data, waiting for lockedtodata (with timeout)
// RX_DRST  | digital reset held while lockedtodata stays high
// RX_READY | channel running; lockedtodata loss re-sequences
module wr_phy_rx_rst_chan
   import wr_phy_rst_pkg::*;
#(
   parameter int g_analog_rst_cycles  = 100,
   parameter int g_digital_rst_cycles = 100,
   parameter int g_ltr_settle_cycles  = 1000,
   parameter int g_ltd_timeout_cycles = 100000,
   parameter int g_cnt_width          = 8
)(
   input  logic                   clk_sys_i,
   input  logic                   rst_i,
   input  logic                   rx_enable_i,
   input  logic                   rx_cal_busy_i,
   input  logic                   rx_is_lockedtoref_i,
   input  logic                   rx_is_lockedtodata_i,
   input  logic                   tx_ready_i,
   input  logic                   tx_drop_i,
   input  logic                   relock_clr_i,
   output logic                   rx_analogreset_o,
   output logic                   rx_digitalreset_o,
   output logic                   rx_set_locktoref_o,
   output logic                   rx_set_locktodata_o,
   output logic                   rx_ready_o,
   output logic [g_cnt_width-1:0] relock_cnt_o
);

   localparam int c_arst = f_max(g_analog_rst_cycles,  c_min_analog_rst_cycles);
   localparam int c_drst = f_max(g_digital_rst_cycles, c_min_digital_rst_cycles);
   localparam int c_ltr  = f_max(g_ltr_settle_cycles,  c_min_ltr_settle_cycles);
   localparam int c_ltd  = f_max(g_ltd_timeout_cycles, c_min_ltd_timeout_cycles);
   localparam int c_tmr_w = f_log2_size(f_max(f_max(c_arst, c_drst), f_max(c_ltr, c_ltd)));

   localparam logic [c_tmr_w-1:0] c_arst_load = c_tmr_w'(c_arst - 1);
   localparam logic [c_tmr_w-1:0] c_drst_load = c_tmr_w'(c_drst - 1);
   localparam logic [c_tmr_w-1:0] c_ltr_load  = c_tmr_w'(c_ltr - 1);
   localparam logic [c_tmr_w-1:0] c_ltd_load  = c_tmr_w'(c_ltd - 1);

   t_rx_state          state, state_nxt;
   logic [c_tmr_w-1:0] tmr, tmr_nxt;
   logic               relock_inc;

   always_comb begin
      state_nxt  = state;
      tmr_nxt    = tmr;
      relock_inc = 1'b0;
      unique case (state)
         RX_ARST: begin
            if (tmr == '0) state_nxt = RX_WAIT;
            else           tmr_nxt   = tmr - 1'b1;
         end
         RX_WAIT: begin
            if (!rx_cal_busy_i && tx_ready_i) begin
               state_nxt = RX_LTR;
               tmr_nxt   = c_ltr_load;
            end
         end
         RX_LTR: begin
            // any low sample restarts the settle window
            if (!rx_is_lockedtoref_i) tmr_nxt = c_ltr_load;
            else if (tmr == '0) begin
               state_nxt = RX_LTD;
               tmr_nxt   = c_ltd_load;
            end
            else tmr_nxt = tmr - 1'b1;
         end
         RX_LTD: begin
            if (rx_is_lockedtodata_i) begin
               state_nxt = RX_DRST;
               tmr_nxt   = c_drst_load;
            end
            else if (tmr == '0) begin
               state_nxt  = RX_ARST;
               tmr_nxt    = c_arst_load;
               relock_inc = 1'b1;
            end
            else tmr_nxt = tmr - 1'b1;
         end
         RX_DRST: begin
            if (!rx_is_lockedtodata_i) begin
               state_nxt  = RX_ARST;
               tmr_nxt    = c_arst_load;
               relock_inc = 1'b1;
            end
            else if (tmr == '0) state_nxt = RX_READY;
            else                tmr_nxt   = tmr - 1'b1;
         end
         RX_READY: begin
            if (!rx_is_lockedtodata_i) begin
               state_nxt  = RX_ARST;
               tmr_nxt    = c_arst_load;
               relock_inc = 1'b1;
            end
         end
         default: begin
            state_nxt = RX_ARST;
            tmr_nxt   = c_arst_load;
         end
      endcase

      // administrative resets are not lock losses, so they never count
      if (!rx_enable_i || tx_drop_i) begin
         state_nxt  = RX_ARST;
         tmr_nxt    = c_arst_load;
         relock_inc = 1'b0;
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         state               <= RX_ARST;
         tmr                 <= c_arst_load;
         rx_analogreset_o    <= 1'b1;
         rx_digitalreset_o   <= 1'b1;
         rx_set_locktoref_o  <= 1'b0;
         rx_set_locktodata_o <= 1'b0;
         rx_ready_o          <= 1'b0;
         relock_cnt_o        <= '0;
      end
      else begin
         state               <= state_nxt;
         tmr                 <= tmr_nxt;
         rx_analogreset_o    <= (state_nxt == RX_ARST);
         rx_digitalreset_o   <= (state_nxt != RX_READY);
         rx_set_locktoref_o  <= (state_nxt == RX_LTR);
         // CDR stays in lock-to-data once it has been told to go there
         rx_set_locktodata_o <= (state_nxt == RX_LTD) || (state_nxt == RX_DRST) ||
                                (state_nxt == RX_READY);
         rx_ready_o          <= (state_nxt == RX_READY);
         if (relock_clr_i)
            relock_cnt_o <= '0;
         else if (relock_inc && (relock_cnt_o != '1))
            relock_cnt_o <= relock_cnt_o + 1'b1;
      end
   end

endmodule

// File: rtl/wr_phy_multi_rst_seq.sv
// Reset and lock sequencer for g_num_channels WR transceiver channels.
// Holds the shared TX FSM and the input synchronisers; one RX FSM per channel.
// Ports:
//   clk_sys_i, rst_i          clock, synchronous active-high reset
//   pll_locked_i              TX PLL lock (async)
//   rx_enable_i[N]            per-channel enable (sync)
//   tx/rx_cal_busy_i[N]       PHY calibration busy (async)
//   rx_is_lockedto*_i[N]      CDR lock status (async)
//   tx_*reset_o[N]            shared TX resets, all bits equal
//   rx_*reset_o[N], rx_set_locktoref_o[N], rx_set_locktodata_o[N]
//   tx_ready_o, rx_ready_o[N] ready flags
//   relock_cnt_o[N*W]         per-channel relock count, channel k at [k*W +: W]
//   relock_clr_i              clear all relock counters
//
// state    | meaning
// ---------+-------------------------------------------------------------
// TX_ARST  | analog+digital reset held for the analog reset time
// TX_WAIT  | analog released, waiting for PLL lock and all tx_cal_busy low
// TX_DRST  | digital reset held for the digital reset time
// TX_READY | TX path running
module wr_phy_multi_rst_seq
   import wr_phy_rst_pkg::*;
#(
   parameter int g_num_channels       = 1,
   parameter int g_analog_rst_cycles  = 100,
   parameter int g_digital_rst_cycles = 100,
   parameter int g_ltr_settle_cycles  = 1000,
   parameter int g_ltd_timeout_cycles = 100000,
   parameter int g_cnt_width          = 8
)(
   input  logic                                  clk_sys_i,
   input  logic                                  rst_i,
   input  logic                                  pll_locked_i,
   input  logic [g_num_channels-1:0]             rx_enable_i,
   input  logic [g_num_channels-1:0]             tx_cal_busy_i,
   input  logic [g_num_channels-1:0]             rx_cal_busy_i,
   input  logic [g_num_channels-1:0]             rx_is_lockedtoref_i,
   input  logic [g_num_channels-1:0]             rx_is_lockedtodata_i,
   output logic [g_num_channels-1:0]             tx_analogreset_o,
   output logic [g_num_channels-1:0]             tx_digitalreset_o,
   output logic [g_num_channels-1:0]             rx_analogreset_o,
   output logic [g_num_channels-1:0]             rx_digitalreset_o,
   output logic [g_num_channels-1:0]             rx_set_locktoref_o,
   output logic [g_num_channels-1:0]             rx_set_locktodata_o,
   output logic                                  tx_ready_o,
   output logic [g_num_channels-1:0]             rx_ready_o,
   output logic [g_num_channels*g_cnt_width-1:0] relock_cnt_o,
   input  logic                                  relock_clr_i
);

   localparam int c_n       = g_num_channels;
   localparam int c_async_w = 1 + 4*c_n;
   localparam int c_arst    = f_max(g_analog_rst_cycles,  c_min_analog_rst_cycles);
   localparam int c_drst    = f_max(g_digital_rst_cycles, c_min_digital_rst_cycles);
   localparam int c_tmr_w   = f_log2_size(f_max(c_arst, c_drst));

   localparam logic [c_tmr_w-1:0] c_arst_load = c_tmr_w'(c_arst - 1);
   localparam logic [c_tmr_w-1:0] c_drst_load = c_tmr_w'(c_drst - 1);

   logic [c_async_w-1:0] async_in, sync_ff1, sync_ff2;
   logic                 pll_s, pll_q, pll_fall;
   logic [c_n-1:0]       tx_cal_s, rx_cal_s, ltr_s, ltd_s;

   assign async_in = {pll_locked_i, tx_cal_busy_i, rx_cal_busy_i,
                      rx_is_lockedtoref_i, rx_is_lockedtodata_i};

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         sync_ff1 <= '0;
         sync_ff2 <= '0;
         pll_q    <= 1'b0;
      end
      else begin
         sync_ff1 <= async_in;
         sync_ff2 <= sync_ff1;
         pll_q    <= pll_s;
      end
   end

   assign {pll_s, tx_cal_s, rx_cal_s, ltr_s, ltd_s} = sync_ff2;
   assign pll_fall = pll_q & ~pll_s;

   t_tx_state          tx_state, tx_state_nxt;
   logic [c_tmr_w-1:0] tx_tmr, tx_tmr_nxt;
   logic               tx_drop;

   always_comb begin
      tx_state_nxt = tx_state;
      tx_tmr_nxt   = tx_tmr;
      unique case (tx_state)
         TX_ARST: begin
            if (tx_tmr == '0) tx_state_nxt = TX_WAIT;
            else              tx_tmr_nxt   = tx_tmr - 1'b1;
         end
         TX_WAIT: begin
            // only a lock that is lost here restarts analog reset; a PLL that
            // never locked just keeps us waiting
            if (pll_fall) begin
               tx_state_nxt = TX_ARST;
               tx_tmr_nxt   = c_arst_load;
            end
            else if (pll_s && (tx_cal_s == '0)) begin
               tx_state_nxt = TX_DRST;
               tx_tmr_nxt   = c_drst_load;
            end
         end
         TX_DRST: begin
            if (!pll_s) begin
               tx_state_nxt = TX_ARST;
               tx_tmr_nxt   = c_arst_load;
            end
            else if (tx_tmr == '0) tx_state_nxt = TX_READY;
            else                   tx_tmr_nxt   = tx_tmr - 1'b1;
         end
         TX_READY: begin
            if (!pll_s) begin
               tx_state_nxt = TX_ARST;
               tx_tmr_nxt   = c_arst_load;
            end
         end
      endcase
   end

   // RX channels react on the same edge tx_ready_o falls
   assign tx_drop = tx_ready_o && (tx_state_nxt != TX_READY);

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         tx_state          <= TX_ARST;
         tx_tmr            <= c_arst_load;
         tx_analogreset_o  <= '1;
         tx_digitalreset_o <= '1;
         tx_ready_o        <= 1'b0;
      end
      else begin
         tx_state          <= tx_state_nxt;
         tx_tmr            <= tx_tmr_nxt;
         tx_analogreset_o  <= {c_n{tx_state_nxt == TX_ARST}};
         tx_digitalreset_o <= {c_n{tx_state_nxt != TX_READY}};
         tx_ready_o        <= (tx_state_nxt == TX_READY);
      end
   end

   for (genvar k = 0; k < c_n; k++) begin : g_rx_chan
      wr_phy_rx_rst_chan #(
         .g_analog_rst_cycles  (g_analog_rst_cycles),
         .g_digital_rst_cycles (g_digital_rst_cycles),
         .g_ltr_settle_cycles  (g_ltr_settle_cycles),
         .g_ltd_timeout_cycles (g_ltd_timeout_cycles),
         .g_cnt_width          (g_cnt_width)
      ) u_chan (
         .clk_sys_i            (clk_sys_i),
         .rst_i                (rst_i),
         .rx_enable_i          (rx_enable_i[k]),
         .rx_cal_busy_i        (rx_cal_s[k]),
         .rx_is_lockedtoref_i  (ltr_s[k]),
         .rx_is_lockedtodata_i (ltd_s[k]),
         .tx_ready_i           (tx_ready_o),
         .tx_drop_i            (tx_drop),
         .relock_clr_i         (relock_clr_i),
         .rx_analogreset_o     (rx_analogreset_o[k]),
         .rx_digitalreset_o    (rx_digitalreset_o[k]),
         .rx_set_locktoref_o   (rx_set_locktoref_o[k]),
         .rx_set_locktodata_o  (rx_set_locktodata_o[k]),
         .rx_ready_o           (rx_ready_o[k]),
         .relock_cnt_o         (relock_cnt_o[k*g_cnt_width +: g_cnt_width])
      );
   end

endmodule

// File: tb/tb_wr_phy_multi_rst_seq.sv
module tb_wr_phy_multi_rst_seq;

   localparam int c_n = 2;
   localparam int c_a = 4;
   localparam int c_d = 3;
   localparam int c_s = 5;
   localparam int c_t = 20;
   localparam int c_w = 8;

   logic                 clk_sys = 1'b0;
   logic                 rst;
   logic                 pll_locked;
   logic [c_n-1:0]       rx_enable, tx_cal_busy, rx_cal_busy, ltr, ltd;
   logic                 relock_clr;
   logic [c_n-1:0]       tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset;
   logic [c_n-1:0]       set_ltr, set_ltd, rx_ready;
   logic                 tx_ready;
   logic [c_n*c_w-1:0]   relock_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk_sys = ~clk_sys;

   wr_phy_multi_rst_seq #(
      .g_num_channels       (c_n),
      .g_analog_rst_cycles  (c_a),
      .g_digital_rst_cycles (c_d),
      .g_ltr_settle_cycles  (c_s),
      .g_ltd_timeout_cycles (c_t),
      .g_cnt_width          (c_w)
   ) dut (
      .clk_sys_i            (clk_sys),
      .rst_i                (rst),
      .pll_locked_i         (pll_locked),
      .rx_enable_i          (rx_enable),
      .tx_cal_busy_i        (tx_cal_busy),
      .rx_cal_busy_i        (rx_cal_busy),
      .rx_is_lockedtoref_i  (ltr),
      .rx_is_lockedtodata_i (ltd),
      .tx_analogreset_o     (tx_analogreset),
      .tx_digitalreset_o    (tx_digitalreset),
      .rx_analogreset_o     (rx_analogreset),
      .rx_digitalreset_o    (rx_digitalreset),
      .rx_set_locktoref_o   (set_ltr),
      .rx_set_locktodata_o  (set_ltd),
      .tx_ready_o           (tx_ready),
      .rx_ready_o           (rx_ready),
      .relock_cnt_o         (relock_cnt),
      .relock_clr_i         (relock_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      @(negedge clk_sys);
   endtask

   task automatic chk_rst_vals(input string tag);
      chk({tag, "_tx_arst"}, 32'(tx_analogreset),  32'h3);
      chk({tag, "_tx_drst"}, 32'(tx_digitalreset), 32'h3);
      chk({tag, "_rx_arst"}, 32'(rx_analogreset),  32'h3);
      chk({tag, "_rx_drst"}, 32'(rx_digitalreset), 32'h3);
      chk({tag, "_set_ltr"}, 32'(set_ltr),         32'h0);
      chk({tag, "_set_ltd"}, 32'(set_ltd),         32'h0);
      chk({tag, "_tx_rdy"},  32'(tx_ready),        32'h0);
      chk({tag, "_rx_rdy"},  32'(rx_ready),        32'h0);
      chk({tag, "_relock"},  32'(relock_cnt),      32'h0);
   endtask

   task automatic wait_rx0(input logic val, input string tag);
      int n;
      n = 0;
      while (rx_ready[0] !== val && n < 200) begin
         step();
         n++;
      end
      chk(tag, 32'(rx_ready[0]), 32'(val));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int exp_cnt;
      int n;
      rst         = 1'b1;
      pll_locked  = 1'b1;
      rx_enable   = 2'b11;
      tx_cal_busy = 2'b00;
      rx_cal_busy = 2'b00;
      ltr         = 2'b10;   // ch1 locked-to-ref throughout, ch0 driven by script
      ltd         = 2'b00;
      relock_clr  = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk_rst_vals("reset");

      // cycle k below is the negedge after the k-th edge following release
      rst = 1'b0;
      for (int k = 0; k <= 43; k++) begin
         step();
         case (k)
            2:  chk("tx_arst_held",   32'(tx_analogreset), 32'h3);
            3:  chk("tx_arst_fall",   32'(tx_analogreset), 32'h0);
            6:  begin
                   chk("tx_rdy_low",    32'(tx_ready),        32'h0);
                   chk("tx_drst_held",  32'(tx_digitalreset), 32'h3);
                end
            7:  begin
                   chk("tx_rdy_rise",   32'(tx_ready),        32'h1);
                   chk("tx_drst_fall",  32'(tx_digitalreset), 32'h0);
                   chk("rx_arst_rel",   32'(rx_analogreset),  32'h0);
                   chk("ltr_pre",       32'(set_ltr),         32'h0);
                end
            8:  begin
                   chk("ltr_enter",     32'(set_ltr), 32'h3);
                   ltr[0] = 1'b1;
                end
            11: ltr[0] = 1'b0;
            12: begin
                   ltr[0] = 1'b1;
                   chk("ltd_none",      32'(set_ltd), 32'h0);
                end
            13: begin
                   chk("ltd_ch1",       32'(set_ltd), 32'h2);
                   chk("ltr_ch0_only",  32'(set_ltr), 32'h1);
                end
            18: chk("ltd0_settle_wait", 32'(set_ltd), 32'h2);
            19: begin
                   chk("ltd0_settled",  32'(set_ltd), 32'h3);
                   chk("ltr_all_off",   32'(set_ltr), 32'h0);
                   ltd[0] = 1'b1;
                end
            24: begin
                   chk("rx0_drst_held", 32'(rx_digitalreset), 32'h3);
                   chk("rx0_not_rdy",   32'(rx_ready),        32'h0);
                end
            25: begin
                   chk("rx0_rdy",       32'(rx_ready),        32'h1);
                   chk("rx0_drst_fall", 32'(rx_digitalreset), 32'h2);
                end
            32: begin
                   chk("ch1_ltd_last",  32'(set_ltd[1]),        32'h1);
                   chk("ch1_relock_0",  32'(relock_cnt[15:8]),  32'h0);
                end
            33: begin
                   chk("ch1_timeout",   32'(set_ltd),           32'h1);
                   chk("ch1_relock_1",  32'(relock_cnt[15:8]),  32'h1);
                   chk("ch0_relock_0",  32'(relock_cnt[7:0]),   32'h0);
                   chk("ch1_arst",      32'(rx_analogreset),    32'h2);
                   chk("ch0_still_rdy", 32'(rx_ready),          32'h1);
                   rx_enable[1] = 1'b0;
                end
            40: pll_locked = 1'b0;
            42: begin
                   chk("pll_drop_tx_hold", 32'(tx_ready), 32'h1);
                   chk("pll_drop_rx_hold", 32'(rx_ready), 32'h1);
                end
            43: begin
                   chk("pll_drop_tx_rdy",  32'(tx_ready),       32'h0);
                   chk("pll_drop_tx_arst", 32'(tx_analogreset), 32'h3);
                   chk("pll_drop_rx_rdy",  32'(rx_ready),       32'h0);
                   chk("pll_drop_rx_arst", 32'(rx_analogreset), 32'h3);
                   chk("pll_drop_relock",  32'(relock_cnt),     32'h0100);
                   pll_locked = 1'b1;
                end
            default: ;
         endcase
      end

      wait_rx0(1'b1, "rx0_rdy_after_pll");

      // repeated lock loss, counter must stop at 255
      exp_cnt = 0;
      for (int i = 1; i <= 300; i++) begin
         ltd[0] = 1'b0;
         wait_rx0(1'b0, "rx0_loss");
         ltd[0] = 1'b1;
         if (exp_cnt < 255) exp_cnt++;
         chk("relock0_cnt", 32'(relock_cnt[7:0]), 32'(exp_cnt));
         wait_rx0(1'b1, "rx0_relock");
      end
      chk("relock0_sat",   32'(relock_cnt[7:0]),  32'd255);
      chk("relock1_keep",  32'(relock_cnt[15:8]), 32'd1);

      // clear on the same edge as a lock loss
      ltd[0] = 1'b0;
      step();
      step();
      chk("clr_pre_loss", 32'(rx_ready[0]), 32'h1);
      relock_clr = 1'b1;
      step();
      relock_clr = 1'b0;
      chk("clr_loss_edge", 32'(rx_ready[0]), 32'h0);
      chk("clr_wins",      32'(relock_cnt),  32'h0);
      step();
      chk("clr_stays",     32'(relock_cnt),  32'h0);

      // ch0 times out once, then reset lands while it is back in RX_LTD
      n = 0;
      while (relock_cnt[7:0] !== 8'd1 && n < 200) begin
         step();
         n++;
      end
      chk("ch0_timeout_cnt", 32'(relock_cnt[7:0]), 32'd1);
      n = 0;
      while (set_ltd[0] !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      chk("ch0_in_ltd", 32'(set_ltd[0]), 32'h1);
      rst = 1'b1;
      step();
      chk_rst_vals("mid_rst");
      rst = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
